// File: rtl/disp_pkg.sv
// Shared definitions for the display arbiter: FSM states, default
// requester count and display data width.
package disp_pkg;

  localparam int unsigned N_REQ_DEF = 3;
  localparam int unsigned DATA_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/tick_gen.sv
// Dwell timing: free-running prescaler producing a one-cycle tick on wrap,
// plus a tick counter. Prescaler held at zero whenever not running.
module tick_gen #(
  parameter int unsigned TICK_DIV = 16,
  parameter int unsigned DWELL_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               run,
  output logic               tick,
  output logic [DWELL_W-1:0] dwell
);

  logic [TICK_DIV-1:0] presc_q, presc_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;

  assign tick  = run & (&presc_q);
  assign dwell = dwell_q;

  always_comb begin
    presc_d = presc_q;
    dwell_d = dwell_q;
    if (clear || !run) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end
    if (clear) begin
      dwell_d = '0;
    end else if (tick) begin
      dwell_d = dwell_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      dwell_q <= '0;
    end else begin
      presc_q <= presc_d;
      dwell_q <= dwell_d;
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin arbiter sharing one 2-digit display value among N_REQ
// requesters; each grant holds the display for a fixed dwell time.
module display_arbiter
  import disp_pkg::*;
#(
  parameter int unsigned N_REQ       = N_REQ_DEF,
  parameter int unsigned TICK_DIV    = 16,
  parameter int unsigned DWELL_TICKS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [DATA_W*N_REQ-1:0] data,
  output logic [DATA_W-1:0]       num_out,
  output logic [N_REQ-1:0]        gnt,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned DWELL_W = $clog2(DWELL_TICKS + 1);

  state_t              state_q, state_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [DATA_W-1:0]   num_q, num_d;
  logic [IDX_W-1:0]    last_q, last_d;

  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    gnt_idx;
  logic                tg_clear, tg_run, tick;
  logic [DWELL_W-1:0]  dwell;

  tick_gen #(
    .TICK_DIV (TICK_DIV),
    .DWELL_W  (DWELL_W)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (tg_clear),
    .run   (tg_run),
    .tick  (tick),
    .dwell (dwell)
  );

  // Search starts just after the last winner, so the winner itself is tried last.
  always_comb begin
    int unsigned idx;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(last_q) + k) % N_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_q[i]) gnt_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    num_d    = num_q;
    last_d   = last_q;
    tg_clear = 1'b0;
    tg_run   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tg_clear = 1'b1;
        if (win_found) begin
          gnt_d   = N_REQ'(1) << win_idx;
          num_d   = data[32'(win_idx)*DATA_W +: DATA_W];
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        tg_run = 1'b1;
        if (tick && (dwell == DWELL_W'(DWELL_TICKS - 1))) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        gnt_d   = '0;
        last_d  = gnt_idx;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      num_q   <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      num_q   <= num_d;
      last_q  <= last_d;
    end
  end

  assign num_out = num_q;
  assign gnt     = gnt_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_RELEASE);

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter against a grant-timeline model
// (time since grant, owner, last winner) derived from the dwell arithmetic.
module tb_display_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned TD = 2;
  localparam int unsigned DT = 3;
  localparam int          H  = DT * (1 << TD);

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [8*N-1:0] data;
  logic [7:0]     num_out;
  logic [N-1:0]   gnt;
  logic           busy;
  logic           done;

  int n_asrt;
  int n_fail;

  // model: active grant, cycles since grant edge, owner, last winner, shown value
  int         m_active;
  int         m_t;
  int         m_owner;
  int         m_last;
  logic [7:0] m_num;

  display_arbiter #(
    .N_REQ       (N),
    .TICK_DIV    (TD),
    .DWELL_TICKS (DT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .data    (data),
    .num_out (num_out),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_t      = 0;
    m_owner  = 0;
    m_last   = N - 1;
    m_num    = 8'h00;
  endtask

  task automatic model_edge();
    int idx;
    logic found;
    if (!rst) begin
      model_reset();
    end else if (m_active != 0) begin
      m_t++;
      if (m_t == H + 1) begin
        m_active = 0;
        m_last   = m_owner;
      end
    end else if (req != '0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (!found && req[idx]) begin
          found   = 1'b1;
          m_owner = idx;
        end
      end
      m_active = 1;
      m_t      = 0;
      m_num    = data[8*m_owner +: 8];
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] eg;
    eg = '0;
    if (m_active != 0) eg[m_owner] = 1'b1;
    chk({tag, ".gnt"},  8'(gnt), 8'(eg));
    chk({tag, ".num"},  num_out, m_num);
    chk({tag, ".busy"}, 8'(busy), 8'(m_active != 0));
    chk({tag, ".done"}, 8'(done), 8'((m_active != 0) && (m_t == H)));
    chk({tag, ".onehot0"}, 8'($onehot0(gnt)), 8'h01);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check_all("rst");
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    n_asrt = 0;
    n_fail = 0;
    rst    = 1'b0;
    req    = '0;
    data   = '0;
    model_reset();
    #12;
    check_all("por");
    rst = 1'b1;

    // single request, full dwell, done then gnt clears
    data[7:0] = 8'hA5;
    req = 3'b001;
    step("t1_grant");
    chk("t1_gnt_const", 8'(gnt), 8'h01);
    chk("t1_num_const", num_out, 8'hA5);
    req = 3'b000;
    for (int i = 0; i < H + 3; i++) step("t1");

    // all requesting: round-robin 11,22,33,11 every H+2 cycles
    do_reset();
    data = {8'h33, 8'h22, 8'h11};
    req  = 3'b111;
    for (int g = 0; g < 4; g++) begin
      step("t2_grant");
      for (int i = 0; i < H + 1; i++) step("t2");
    end
    req = 3'b000;
    for (int i = 0; i < H + 2; i++) step("t2_tail");

    // data change and request drop during hold do not disturb the display
    do_reset();
    data[15:8] = 8'h3C;
    req = 3'b010;
    step("t3_grant");
    chk("t3_num_const", num_out, 8'h3C);
    for (int i = 0; i < 4; i++) step("t3");
    data[15:8] = 8'hC3;
    req = 3'b000;
    for (int i = 0; i < H; i++) step("t3_hold");
    chk("t3_num_final", num_out, 8'h3C);

    // short request while another holds the grant is lost
    do_reset();
    data = {8'h77, 8'h66, 8'h55};
    req  = 3'b001;
    step("t4_grant");
    req = 3'b000;
    step("t4");
    req = 3'b100;
    for (int i = 0; i < 3; i++) step("t4_pulse");
    req = 3'b000;
    for (int i = 0; i < H + 2; i++) step("t4_tail");
    chk("t4_gnt_idle", 8'(gnt), 8'h00);

    // asynchronous reset mid-hold
    data = {8'h99, 8'h88, 8'h44};
    req  = 3'b001;
    step("t5_grant");
    req = 3'b000;
    for (int i = 0; i < 5; i++) step("t5");
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("t5_async_gnt",  8'(gnt), 8'h00);
    chk("t5_async_num",  num_out, 8'h00);
    chk("t5_async_busy", 8'(busy), 8'h00);
    chk("t5_async_done", 8'(done), 8'h00);
    for (int i = 0; i < 3; i++) step("t5_inrst");
    #2;
    rst = 1'b1;
    req = 3'b110;
    step("t5_regrant");
    chk("t5_first_is_1", 8'(gnt), 8'h02);
    chk("t5_num_1", num_out, 8'h88);
    req = 3'b000;
    for (int i = 0; i < H + 2; i++) step("t5_tail");

    // randomized requests and data
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 7));
      data = 24'($urandom);
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
